// File: rtl/adc_capture_avg.sv
// Multi-channel ADC capture with runtime-selectable 2^k boxcar averaging.
// Optional per-channel offset subtraction: define ADC_CAPTURE_AVG_OFFSET_EN.
module adc_capture_avg #(
  parameter int W_AIO   = 14,
  parameter int N_CH    = 2,
  parameter int LOG_AVG = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   adc_smp,
  input  logic [N_CH*W_AIO-1:0]  adc_in,
`ifdef ADC_CAPTURE_AVG_OFFSET_EN
  input  logic [N_CH*W_AIO-1:0]  ofs_in,
`endif
  input  logic [3:0]             avg_log,
  output logic [N_CH*W_AIO-1:0]  aio_out,
  output logic                   aio_vld,
  output logic [N_CH-1:0]        aio_ovr,
  output logic [15:0]            blk_cnt
);

  localparam int ACC_W = W_AIO + LOG_AVG;
  localparam int CNT_W = LOG_AVG + 1;
  localparam logic [3:0] MAX_LOG = 4'(LOG_AVG);

  function automatic logic is_ovr(input logic [W_AIO-1:0] v);
    return (v == {1'b0, {(W_AIO-1){1'b1}}}) || (v == {1'b1, {(W_AIO-1){1'b0}}});
  endfunction

  function automatic logic [W_AIO-1:0] sat_sub(input logic [W_AIO-1:0] a,
                                               input logic [W_AIO-1:0] b);
    logic [W_AIO:0] d;
    d = {a[W_AIO-1], a} - {b[W_AIO-1], b};
    if (d[W_AIO] != d[W_AIO-1]) begin
      return d[W_AIO] ? {1'b1, {(W_AIO-1){1'b0}}} : {1'b0, {(W_AIO-1){1'b1}}};
    end else begin
      return d[W_AIO-1:0];
    end
  endfunction

  function automatic logic signed [ACC_W-1:0] sext(input logic signed [W_AIO-1:0] v);
    return ACC_W'(v);
  endfunction

  logic                          sync1_q, sync1_d, sync2_q, sync2_d, hist_q, hist_d;
  logic [N_CH*W_AIO-1:0]         adc_buf_q, adc_buf_d;
  logic                          s1_vld_q, s1_vld_d;
  logic [N_CH*W_AIO-1:0]         cap_q, cap_d;
  logic [N_CH-1:0]               ovr_raw_q, ovr_raw_d;
  logic signed [ACC_W-1:0]       acc_q [N_CH];
  logic signed [ACC_W-1:0]       acc_d [N_CH];
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [3:0]                    eff_blk_q, eff_blk_d;
  logic [N_CH-1:0]               ovr_acc_q, ovr_acc_d;
  logic                          res_vld_q, res_vld_d;
  logic signed [ACC_W-1:0]       res_sum_q [N_CH];
  logic signed [ACC_W-1:0]       res_sum_d [N_CH];
  logic [3:0]                    res_log_q, res_log_d;
  logic [N_CH-1:0]               res_ovr_q, res_ovr_d;
  logic [N_CH*W_AIO-1:0]         aio_out_q, aio_out_d;
  logic                          aio_vld_q, aio_vld_d;
  logic [N_CH-1:0]               aio_ovr_q, aio_ovr_d;
  logic [15:0]                   blk_cnt_q, blk_cnt_d;

  logic                          e_smp;
  logic                          first_s;
  logic                          last_s;
  logic [3:0]                    eff_now_s;
  logic [3:0]                    eff_cur_s;
  logic [CNT_W-1:0]              last_cnt_s;
  logic [N_CH-1:0]               ovr_blk_s;
  logic signed [ACC_W-1:0]       sum_s [N_CH];
  logic signed [ACC_W-1:0]       shr_s;
  logic [W_AIO-1:0]              raw_s;

  assign aio_out = aio_out_q;
  assign aio_vld = aio_vld_q;
  assign aio_ovr = aio_ovr_q;
  assign blk_cnt = blk_cnt_q;

  // Next-state logic for synchroniser, capture, accumulate and output stages
  always_comb begin
    sync1_d   = adc_smp;
    sync2_d   = sync1_q;
    hist_d    = sync2_q;
    e_smp     = sync2_q & ~hist_q;
    adc_buf_d = adc_in;
    s1_vld_d  = e_smp;
    cap_d     = cap_q;
    ovr_raw_d = ovr_raw_q;
    raw_s     = '0;
    if (e_smp) begin
      for (int c = 0; c < N_CH; c++) begin
        raw_s = adc_buf_q[c*W_AIO +: W_AIO];
`ifdef ADC_CAPTURE_AVG_OFFSET_EN
        cap_d[c*W_AIO +: W_AIO] = sat_sub(raw_s, ofs_in[c*W_AIO +: W_AIO]);
`else
        cap_d[c*W_AIO +: W_AIO] = raw_s;
`endif
        ovr_raw_d[c] = is_ovr(raw_s);
      end
    end else begin
      cap_d = cap_q;
    end

    // The block length is fixed by eff_log seen when its first sample arrives
    eff_now_s  = (avg_log > MAX_LOG) ? MAX_LOG : avg_log;
    first_s    = (cnt_q == '0);
    eff_cur_s  = first_s ? eff_now_s : eff_blk_q;
    last_cnt_s = CNT_W'((32'd1 << eff_cur_s) - 32'd1);
    last_s     = (cnt_q == last_cnt_s);
    ovr_blk_s  = (first_s ? '0 : ovr_acc_q) | ovr_raw_q;

    acc_d     = acc_q;
    cnt_d     = cnt_q;
    eff_blk_d = eff_blk_q;
    ovr_acc_d = ovr_acc_q;
    res_vld_d = 1'b0;
    res_sum_d = res_sum_q;
    res_log_d = res_log_q;
    res_ovr_d = res_ovr_q;
    for (int c = 0; c < N_CH; c++) begin
      sum_s[c] = (first_s ? '0 : acc_q[c]) + sext(cap_q[c*W_AIO +: W_AIO]);
    end
    if (s1_vld_q) begin
      eff_blk_d = eff_cur_s;
      if (last_s) begin
        res_vld_d = 1'b1;
        res_sum_d = sum_s;
        res_log_d = eff_cur_s;
        res_ovr_d = ovr_blk_s;
        cnt_d     = '0;
        ovr_acc_d = '0;
        for (int c = 0; c < N_CH; c++) acc_d[c] = '0;
      end else begin
        acc_d     = sum_s;
        cnt_d     = cnt_q + CNT_W'(1);
        ovr_acc_d = ovr_blk_s;
      end
    end else begin
      cnt_d = cnt_q;
    end

    aio_vld_d = res_vld_q;
    aio_out_d = aio_out_q;
    aio_ovr_d = aio_ovr_q;
    blk_cnt_d = blk_cnt_q;
    shr_s     = '0;
    if (res_vld_q) begin
      for (int c = 0; c < N_CH; c++) begin
        shr_s = res_sum_q[c] >>> res_log_q;
        aio_out_d[c*W_AIO +: W_AIO] = shr_s[W_AIO-1:0];
      end
      aio_ovr_d = res_ovr_q;
      blk_cnt_d = blk_cnt_q + 16'd1;
    end else begin
      blk_cnt_d = blk_cnt_q;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      hist_q    <= 1'b0;
      adc_buf_q <= '0;
      s1_vld_q  <= 1'b0;
      cap_q     <= '0;
      ovr_raw_q <= '0;
      cnt_q     <= '0;
      eff_blk_q <= 4'd0;
      ovr_acc_q <= '0;
      res_vld_q <= 1'b0;
      res_log_q <= 4'd0;
      res_ovr_q <= '0;
      aio_out_q <= '0;
      aio_vld_q <= 1'b0;
      aio_ovr_q <= '0;
      blk_cnt_q <= 16'd0;
      for (int c = 0; c < N_CH; c++) begin
        acc_q[c]     <= '0;
        res_sum_q[c] <= '0;
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      hist_q    <= hist_d;
      adc_buf_q <= adc_buf_d;
      s1_vld_q  <= s1_vld_d;
      cap_q     <= cap_d;
      ovr_raw_q <= ovr_raw_d;
      cnt_q     <= cnt_d;
      eff_blk_q <= eff_blk_d;
      ovr_acc_q <= ovr_acc_d;
      res_vld_q <= res_vld_d;
      res_log_q <= res_log_d;
      res_ovr_q <= res_ovr_d;
      aio_out_q <= aio_out_d;
      aio_vld_q <= aio_vld_d;
      aio_ovr_q <= aio_ovr_d;
      blk_cnt_q <= blk_cnt_d;
      for (int c = 0; c < N_CH; c++) begin
        acc_q[c]     <= acc_d[c];
        res_sum_q[c] <= res_sum_d[c];
      end
    end
  end

endmodule

// File: tb/tb_adc_capture_avg.sv
// Scoreboard bench for adc_capture_avg: directed samples, hand-computed block results.
module tb_adc_capture_avg;
  localparam int W = 14;
  localparam int N = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           adc_smp = 1'b0;
  logic [N*W-1:0] adc_in = '0;
  logic [3:0]     avg_log = 4'd0;
  logic [N*W-1:0] aio_out;
  logic           aio_vld;
  logic [N-1:0]   aio_ovr;
  logic [15:0]    blk_cnt;
`ifdef ADC_CAPTURE_AVG_OFFSET_EN
  logic [N*W-1:0] ofs_in = '0;
`endif

  adc_capture_avg #(.W_AIO(W), .N_CH(N), .LOG_AVG(8)) dut (
    .clk(clk), .rst_n(rst_n), .adc_smp(adc_smp), .adc_in(adc_in),
`ifdef ADC_CAPTURE_AVG_OFFSET_EN
    .ofs_in(ofs_in),
`endif
    .avg_log(avg_log), .aio_out(aio_out), .aio_vld(aio_vld),
    .aio_ovr(aio_ovr), .blk_cnt(blk_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] o0;
    logic [W-1:0] o1;
    logic [1:0]   ovr;
    logic [15:0]  blk;
    int           at;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_blk = 16'd0;
  int          last_raise = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_blk(input int o0, input int o1, input logic [1:0] ovr, input int at);
    exp_t e;
    exp_blk = exp_blk + 16'd1;
    e.o0 = 14'(o0);
    e.o1 = 14'(o1);
    e.ovr = ovr;
    e.blk = exp_blk;
    e.at = at;
    sb.push_back(e);
  endtask

  task automatic send(input int a, input int b);
    @(negedge clk);
    adc_in  = {14'(b), 14'(a)};
    adc_smp = 1'b1;
    last_raise = cyc;
    repeat (2) @(negedge clk);
    adc_smp = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n && aio_vld) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: actual out %0h blk %0h required no strobe", aio_out, blk_cnt);
      end else begin
        mon_e = sb.pop_front();
        chk("out_ch0", 32'(aio_out[W-1:0]), 32'(mon_e.o0));
        chk("out_ch1", 32'(aio_out[2*W-1:W]), 32'(mon_e.o1));
        chk("ovr", 32'(aio_ovr), 32'(mon_e.ovr));
        chk("blk_cnt", 32'(blk_cnt), 32'(mon_e.blk));
        if (mon_e.at >= 0) chk("latency", 32'(cyc), 32'(mon_e.at));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle(3);
    rst_n = 1'b1;
    idle(1);
    chk("rst_out", 32'(aio_out), 32'd0);
    chk("rst_vld", 32'(aio_vld), 32'd0);
    chk("rst_ovr", 32'(aio_ovr), 32'd0);
    chk("rst_blk", 32'(blk_cnt), 32'd0);

    // Single-sample pass-through with latency check
    avg_log = 4'd0;
    send(100, -5);
    expect_blk(100, -5, 2'b00, last_raise + 5);
    idle(4);

    // Floor-rounded average of four
    avg_log = 4'd2;
    send(1, -1); send(2, -1); send(3, -1);
    expect_blk(3, -2, 2'b00, -1);
    send(6, -2);
    idle(10);
    chk("hold_ch0", 32'(aio_out[W-1:0]), 32'(14'd3));

    // Overrange flag is per block
    avg_log = 4'd1;
    send(8191, 0);
    expect_blk(4095, 0, 2'b01, -1);
    send(0, 0);
    send(5, 0);
    expect_blk(5, 0, 2'b00, -1);
    send(5, 0);
    idle(4);

    // Negative full-scale on ch1 flags overrange
    avg_log = 4'd0;
    expect_blk(0, -8192, 2'b10, -1);
    send(0, -8192);
    idle(4);

    // Mid-block change 2 -> 1: current block keeps 4 samples
    avg_log = 4'd2;
    send(4, 0); send(4, 0);
    avg_log = 4'd1;
    send(8, 0);
    expect_blk(6, 0, 2'b00, -1);
    send(8, 0);
    send(10, 0);
    expect_blk(11, 0, 2'b00, -1);
    send(12, 0);
    send(1, 0);
    expect_blk(1, 0, 2'b00, -1);
    send(2, 0);
    idle(4);

    // Request 15 clamps to 8: one strobe after 256 samples
    avg_log = 4'd15;
    for (int i = 0; i < 255; i++) send(7, -3);
    chk("clamp_no_early", 32'(sb.size()), 32'd0);
    expect_blk(7, -3, 2'b00, -1);
    send(7, -3);
    idle(4);

    // Reset mid-block discards the partial block
    avg_log = 4'd2;
    send(100, 100); send(100, 100); send(100, 100);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_blk = 16'd0;
    chk("mid_rst_out", 32'(aio_out), 32'd0);
    chk("mid_rst_ovr", 32'(aio_ovr), 32'd0);
    chk("mid_rst_blk", 32'(blk_cnt), 32'd0);
    send(4, -4); send(4, -4); send(4, -4);
    expect_blk(4, -4, 2'b00, -1);
    send(4, -4);
    idle(4);

`ifdef ADC_CAPTURE_AVG_OFFSET_EN
    // Offset subtraction saturates; overrange looks at the raw sample
    avg_log = 4'd0;
    ofs_in = {14'd0, 14'd10};
    expect_blk(-8192, 0, 2'b00, -1);
    send(-8190, 0);
    expect_blk(-8192, 0, 2'b01, -1);
    send(-8192, 0);
    idle(4);
    ofs_in = '0;
`endif

    // Block counter wrap, preloaded near the top
    @(negedge clk);
    force dut.blk_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.blk_cnt_q;
    exp_blk = 16'hFFFE;
    idle(1);
    chk("preload_blk", 32'(blk_cnt), 32'h0000FFFE);
    avg_log = 4'd0;
    expect_blk(1, 1, 2'b00, -1);
    send(1, 1);
    expect_blk(2, 2, 2'b00, -1);
    send(2, 2);

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    idle(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
